mii_frame_monitor: RTL and testbench
====================================

// Module: mii_frame_monitor
// PURPOSE
//  Parametrised successor to the 64-bit MII checker: passive, cycle-accurate monitor for a wide
//  xGMII-style TX bus (generator -> PCS) with N = DATA_WIDTH/8 byte lanes, ctrl bit k flagging byte k.
//  Parses START/TERM/IDLE framing per lane, measures payload length and inter-packet gap in bytes,
//  flags framing, length and gap violations; optional saturating statistics.
// PARAMETERS
//  DATA_WIDTH  64     bus width; multiple of 64, 64..1024
//  CTRL_WIDTH  8      DATA_WIDTH/8; one ctrl bit per byte lane
//  IDLE_CODE   8'h07  idle control byte
//  START_CODE  8'hFB  start control byte; legal only in lane 0
//  TERM_CODE   8'hFD  terminate control byte; any lane
//  MIN_FRAME   64     min payload bytes (data bytes strictly between START and TERM)
//  MAX_FRAME   1518   max payload bytes
//  MIN_IPG     12     min idle bytes from byte after TERM to byte before next START
//  CNT_W       32     statistics counter width
// PORTS
//  clk             in   1           rising-edge clock
//  i_rst           in   1           synchronous reset, active high
//  i_tx_data       in   DATA_WIDTH  monitored data, lane k = bits [8k+7:8k]
//  i_tx_ctrl       in   CTRL_WIDTH  lane k is control when bit k = 1
//  payload_error   out  1           1-cycle pulse: frame ended with length < MIN_FRAME or > MAX_FRAME
//  intergap_error  out  1           1-cycle pulse: START seen with preceding gap < MIN_IPG
//  other_error     out  1           1-cycle pulse: framing/code violation
//  o_in_frame      out  1           FSM is in FRAME state
//  o_frame_count   out  CNT_W       well-formed frames (MII_MON_STATS_EN)
//  o_error_count   out  CNT_W       cycles with any error pulse (MII_MON_STATS_EN)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, len_cnt=0, ipg_cnt=0, first_frame=1. i_rst wins over any input;
//    a frame in progress at reset is discarded, nothing flagged.
//  - All outputs registered; a pulse is asserted the cycle after the word that caused it (latency 1).
//  - FSM IDLE: lanes must be ctrl=1 & IDLE_CODE; each adds 1 to ipg_cnt (saturates 16'hFFFF).
//    START in lane 0 -> FRAME; if !first_frame and ipg_cnt < MIN_IPG -> intergap_error; clear
//    ipg_cnt, len_cnt, first_frame. Lanes 1..N-1 of START word parsed as FRAME lanes.
//  - FSM FRAME: ctrl=0 lanes add 1 to len_cnt (saturates at MAX_FRAME+1). TERM in lane k -> IDLE;
//    lanes k+1..N-1 must be IDLE and count into ipg_cnt. START+TERM in one word is a legal short frame.
//  - At TERM: len < MIN_FRAME or > MAX_FRAME -> payload_error; else frame counted good.
//  - other_error cases: ctrl=0 byte in IDLE; TERM in IDLE; START in lane != 0; START while in FRAME
//    (frame aborted, restarted, no payload check on aborted frame, no IPG check); any ctrl byte in
//    FRAME other than TERM; non-IDLE byte after TERM in same word; unknown ctrl code anywhere.
//  - Several violations in one word -> each output pulses once; pulses never stretch past 1 cycle.
//  - Counters: saturate at all-ones, never wrap; frame_count +1 per good TERM; error_count +1 per
//    cycle where any error pulse is high.
//  - Lane parse is combinational over N lanes per cycle; no backpressure, every cycle consumed.
// CONFIGURATION
//  MII_MON_STATS_EN defined: o_frame_count/o_error_count implemented as above.
//  Not defined: counters not synthesised, both ports tied to 0; error/state behaviour unchanged.
// TESTING (DATA_WIDTH=64 and 256, defaults otherwise)
//  1 Reset held 2 cycles, idle bus -> all outputs 0, o_in_frame=0, no pulses.
//  2 64-byte payload frame, 12 idle bytes, second 64-byte frame -> no errors; frame_count=2.
//  3 Gap of 8 idle bytes before second START -> intergap_error pulse 1 cycle after START word.
//  4 Payload 60 bytes, then 1519 bytes -> payload_error pulse after each TERM word; frame_count=0.
//  5 START in lane 3, TERM in IDLE, ctrl=0 byte in IDLE, 0xFE ctrl in FRAME -> other_error each.
//  6 i_rst mid-frame then new legal frame with no preceding gap -> no intergap_error, frame_count=1.

Source files
------------

// File: rtl/mii_frame_monitor.sv
// Passive START/TERM/IDLE framing monitor for a wide xGMII-style TX bus (one ctrl bit per byte lane).
// Define MII_MON_STATS_EN to build the saturating frame/error counters; otherwise they read 0.
module mii_frame_monitor #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter logic [7:0]  IDLE_CODE  = 8'h07,
  parameter logic [7:0]  START_CODE = 8'hFB,
  parameter logic [7:0]  TERM_CODE  = 8'hFD,
  parameter int unsigned MIN_FRAME  = 64,
  parameter int unsigned MAX_FRAME  = 1518,
  parameter int unsigned MIN_IPG    = 12,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic [CTRL_WIDTH-1:0] i_tx_ctrl,
  output logic                  payload_error,
  output logic                  intergap_error,
  output logic                  other_error,
  output logic                  o_in_frame,
  output logic [CNT_W-1:0]      o_frame_count,
  output logic [CNT_W-1:0]      o_error_count
);

  localparam int unsigned     Lanes  = CTRL_WIDTH;
  localparam int unsigned     LenW   = $clog2(MAX_FRAME + 2);
  localparam logic [LenW-1:0] LenSat = LenW'(MAX_FRAME + 1);
  localparam logic [LenW-1:0] LenMin = LenW'(MIN_FRAME);
  localparam logic [LenW-1:0] LenMax = LenW'(MAX_FRAME);
  localparam logic [15:0]     IpgMin = 16'(MIN_IPG);

  typedef enum logic [0:0] {StIdle, StFrame} state_e;

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic [15:0]     ipg_q, ipg_d;
  logic            first_q, first_d;
  logic            pay_err_q, pay_err_d;
  logic            ipg_err_q, ipg_err_d;
  logic            oth_err_q, oth_err_d;
  logic            good_d;
  logic [7:0]      code;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      ipg_q     <= '0;
      first_q   <= 1'b1;
      pay_err_q <= 1'b0;
      ipg_err_q <= 1'b0;
      oth_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ipg_q     <= ipg_d;
      first_q   <= first_d;
      pay_err_q <= pay_err_d;
      ipg_err_q <= ipg_err_d;
      oth_err_q <= oth_err_d;
    end
  end

  // Walk the lanes in order; the state seen by lane k is the state left by lane k-1.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ipg_d     = ipg_q;
    first_d   = first_q;
    pay_err_d = 1'b0;
    ipg_err_d = 1'b0;
    oth_err_d = 1'b0;
    good_d    = 1'b0;
    code      = '0;
    for (int unsigned k = 0; k < Lanes; k++) begin
      code = i_tx_data[8*k +: 8];
      if (state_d == StIdle) begin
        if (!i_tx_ctrl[k]) begin
          oth_err_d = 1'b1;
        end else if (code == IDLE_CODE) begin
          if (ipg_d != 16'hFFFF) ipg_d = ipg_d + 16'd1;
        end else if (code == START_CODE && k == 0) begin
          if (!first_d && ipg_d < IpgMin) ipg_err_d = 1'b1;
          state_d = StFrame;
          ipg_d   = '0;
          len_d   = '0;
          first_d = 1'b0;
        end else begin
          // TERM without a frame, START off lane 0, or unknown control code
          oth_err_d = 1'b1;
        end
      end else begin
        if (!i_tx_ctrl[k]) begin
          if (len_d != LenSat) len_d = len_d + LenW'(1);
        end else if (code == TERM_CODE) begin
          state_d = StIdle;
          if (len_d < LenMin || len_d > LenMax) pay_err_d = 1'b1;
          else                                  good_d    = 1'b1;
        end else if (code == START_CODE && k == 0) begin
          // Abort and restart: the aborted frame gets no length or gap check
          oth_err_d = 1'b1;
          len_d     = '0;
          ipg_d     = '0;
        end else begin
          oth_err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_in_frame     = (state_q == StFrame);
    payload_error  = pay_err_q;
    intergap_error = ipg_err_q;
    other_error    = oth_err_q;
  end

`ifdef MII_MON_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (good_d && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      if ((pay_err_d || ipg_err_d || oth_err_d) && err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_frame_count = frame_cnt_q;
  assign o_error_count = err_cnt_q;
`else
  logic unused_good;
  assign unused_good   = good_d;
  assign o_frame_count = '0;
  assign o_error_count = '0;
`endif

endmodule

// File: tb/tb_mii_frame_monitor.sv
// Directed bench for mii_frame_monitor (64-bit bus); counter checks follow MII_MON_STATS_EN.
module tb_mii_frame_monitor;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [63:0] i_tx_data;
  logic [7:0]  i_tx_ctrl;
  logic        payload_error, intergap_error, other_error, o_in_frame;
  logic [31:0] o_frame_count, o_error_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   pe_n = 0, ige_n = 0, oe_n = 0;
  logic ige_at_start, pe_at_term;

  localparam logic [63:0] IdleWord  = {8{8'h07}};
  localparam logic [63:0] StartWord = 64'hA1A2_A3A4_A5A6_A7FB;
  localparam logic [63:0] DataWord  = 64'h0123_4567_89AB_CDEF;

  always #5 clk = ~clk;

  mii_frame_monitor dut (
    .clk            (clk),
    .i_rst          (i_rst),
    .i_tx_data      (i_tx_data),
    .i_tx_ctrl      (i_tx_ctrl),
    .payload_error  (payload_error),
    .intergap_error (intergap_error),
    .other_error    (other_error),
    .o_in_frame     (o_in_frame),
    .o_frame_count  (o_frame_count),
    .o_error_count  (o_error_count)
  );

  always @(negedge clk) begin
    pe_n  += int'(payload_error);
    ige_n += int'(intergap_error);
    oe_n  += int'(other_error);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; on return, outputs reflect the word just driven.
  task automatic drive(input logic [7:0] c, input logic [63:0] d);
    i_tx_ctrl = c;
    i_tx_data = d;
    @(negedge clk);
  endtask

  task automatic idles(input int n);
    repeat (n) drive(8'hFF, IdleWord);
  endtask

  // START word carries 7 payload bytes, then full data words, then TERM in lane len-7 mod 8.
  task automatic send_frame(input int len);
    int          r, k;
    logic [7:0]  c;
    logic [63:0] d;
    drive(8'h01, StartWord);
    ige_at_start = intergap_error;
    r = len - 7;
    repeat (r / 8) drive(8'h00, DataWord);
    k = r % 8;
    for (int i = 0; i < 8; i++) begin
      if (i < k) begin
        c[i] = 1'b0; d[8*i +: 8] = 8'h5A;
      end else if (i == k) begin
        c[i] = 1'b1; d[8*i +: 8] = 8'hFD;
      end else begin
        c[i] = 1'b1; d[8*i +: 8] = 8'h07;
      end
    end
    drive(c, d);
    pe_at_term = payload_error;
  endtask

  task automatic do_reset(input string tag);
    i_rst = 1'b1;
    idles(2);
    check({tag, ".rst_flags"}, {28'd0, payload_error, intergap_error, other_error, o_in_frame},
          32'd0);
    check({tag, ".rst_counts"}, o_frame_count | o_error_count, 32'd0);
    pe_n = 0; ige_n = 0; oe_n = 0;
    i_rst = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int pe, input int ige, input int oe,
                              input int fc, input int ec);
    check({tag, ".payload_pulses"}, pe_n, pe);
    check({tag, ".gap_pulses"}, ige_n, ige);
    check({tag, ".other_pulses"}, oe_n, oe);
`ifdef MII_MON_STATS_EN
    check({tag, ".frame_count"}, o_frame_count, 32'(fc));
    check({tag, ".error_count"}, o_error_count, 32'(ec));
`else
    check({tag, ".frame_count"}, o_frame_count, 32'd0);
    check({tag, ".error_count"}, o_error_count, 32'd0);
`endif
  endtask

  initial begin
    i_rst     = 1'b1;
    i_tx_ctrl = 8'hFF;
    i_tx_data = IdleWord;
    @(negedge clk);

    // 1: reset then idle bus
    do_reset("t1");
    idles(4);
    check("t1.in_frame", o_in_frame, 1'b0);
    check_counts("t1", 0, 0, 0, 0, 0);

    // 2: 66-byte frame, exactly 12 idle bytes, 64-byte frame
    do_reset("t2");
    send_frame(66);
    idles(1);
    send_frame(64);
    check("t2.gap12_ok", ige_at_start, 1'b0);
    check("t2.in_frame_after_term", o_in_frame, 1'b0);
    idles(2);
    check_counts("t2", 0, 0, 0, 2, 0);

    // 3: gaps of 8 and 11 bytes flagged, 14 accepted
    do_reset("t3");
    send_frame(70);
    idles(1);
    send_frame(64);
    check("t3.gap8_pulse", ige_at_start, 1'b1);
    idles(1);
    send_frame(67);
    check("t3.gap14_ok", ige_at_start, 1'b0);
    idles(1);
    send_frame(64);
    check("t3.gap11_pulse", ige_at_start, 1'b1);
    idles(2);
    check_counts("t3", 0, 2, 0, 4, 2);

    // 4: payload length boundaries
    do_reset("t4");
    send_frame(60);
    check("t4.len60", pe_at_term, 1'b1);
    idles(2);
    send_frame(1519);
    check("t4.len1519", pe_at_term, 1'b1);
    idles(2);
    send_frame(63);
    check("t4.len63", pe_at_term, 1'b1);
    idles(2);
    send_frame(64);
    check("t4.len64", pe_at_term, 1'b0);
    idles(2);
    send_frame(1518);
    check("t4.len1518", pe_at_term, 1'b0);
    idles(2);
    check_counts("t4", 3, 0, 0, 2, 3);

    // 5: framing/code violations
    do_reset("t5");
    drive(8'hFF, 64'h0707_0707_FB07_0707);
    check("t5.start_lane3", other_error, 1'b1);
    drive(8'hDF, 64'h0707_55FD_0707_0707);
    check("t5.term_in_idle", other_error, 1'b1);
    drive(8'hFE, 64'h0707_0707_0707_0755);
    check("t5.data_in_idle", other_error, 1'b1);
    idles(2);
    drive(8'h01, StartWord);
    check("t5.in_frame", o_in_frame, 1'b1);
    repeat (8) drive(8'h00, DataWord);
    drive(8'h04, 64'h5A5A_5A5A_5AFE_5A5A);
    check("t5.bad_ctrl_in_frame", other_error, 1'b1);
    drive(8'hFF, 64'h0707_0707_0707_07FD);
    check("t5.len78_ok", payload_error, 1'b0);
    idles(3);
    drive(8'h01, StartWord);
    drive(8'h00, DataWord);
    drive(8'h01, StartWord);
    check("t5.start_in_frame", other_error, 1'b1);
    check("t5.restart_no_gap_chk", intergap_error, 1'b0);
    repeat (8) drive(8'h00, DataWord);
    drive(8'hFF, 64'h0707_0707_0707_07FD);
    check("t5.restart_len71_ok", payload_error, 1'b0);
    idles(2);
    check_counts("t5", 0, 0, 5, 2, 5);

    // 6: reset mid-frame, then a legal frame with no preceding gap
    do_reset("t6");
    drive(8'h01, StartWord);
    repeat (3) drive(8'h00, DataWord);
    i_rst = 1'b1;
    drive(8'h00, DataWord);
    check("t6.mid_rst_flags", {28'd0, payload_error, intergap_error, other_error, o_in_frame},
          32'd0);
    i_rst = 1'b0;
    send_frame(64);
    check("t6.no_gap_pulse", ige_at_start, 1'b0);
    check("t6.len64_ok", pe_at_term, 1'b0);
    idles(2);
    check_counts("t6", 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
